// File: rtl/carry_select_adder_16.sv
// carry_select_adder_16: 16-bit carry-select adder with combinational and registered results
// Ports:
//   clk     - clock for the output registers only
//   rst_n   - synchronous active-low reset of sum_q/c_out_q
//   a, b    - 16-bit operands
//   c_in    - carry into bit 0
//   sum     - combinational a + b + c_in, low 16 bits
//   c_out   - combinational unsigned carry out of bit 15
//   sum_q   - sum registered on rising clk
//   c_out_q - c_out registered on rising clk
module carry_select_adder_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic [15:0] sum_q,
    output logic        c_out_q
);
    // 4-bit ripple adder built from full adders; returns {carry, sum}
    function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [4:0] c;
        logic [3:0] s;
        c[0] = ci;
        for (int k = 0; k < 4; k++) begin
            s[k]     = x[k] ^ y[k] ^ c[k];
            c[k + 1] = (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
        end
        return {c[4], s};
    endfunction

    logic [4:0] lo, hi;
    logic       c;

    // Upper blocks are precomputed for both carry-ins; the carry chain only drives the muxes
    always_comb begin
        lo = '0;
        hi = '0;
        {c, sum[3:0]} = ripple4(a[3:0], b[3:0], c_in);
        for (int k = 1; k < 4; k++) begin
            lo = ripple4(a[4*k +: 4], b[4*k +: 4], 1'b0);
            hi = ripple4(a[4*k +: 4], b[4*k +: 4], 1'b1);
            {c, sum[4*k +: 4]} = c ? hi : lo;
        end
        c_out = c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= 16'h0000;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            c_out_q <= c_out;
        end
    end
endmodule

// File: tb/tb_carry_select_adder_16.sv
// tb_carry_select_adder_16: directed and swept checks of carry_select_adder_16 against an arithmetic model
module tb_carry_select_adder_16;
    logic        clk = 1'b0;
    logic        run_clk = 1'b1;
    logic        rst_n;
    logic [15:0] a, b;
    logic        c_in;
    logic [15:0] sum, sum_q;
    logic        c_out, c_out_q;
    logic [16:0] exp_q;
    logic        chk_q = 1'b0;
    int          passed = 0;
    int          total = 0;

    carry_select_adder_16 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .sum(sum), .c_out(c_out), .sum_q(sum_q), .c_out_q(c_out_q)
    );

    initial forever begin
        #5;
        if (run_clk) clk = ~clk;
    end

    function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {16'b0, ci};
    endfunction

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else passed++;
    endtask

    // Expected register contents: reset clears, otherwise capture the arithmetic result
    always @(posedge clk) exp_q <= rst_n ? model(a, b, c_in) : 17'h0;

    always @(negedge clk) if (chk_q) check("reg_model", {c_out_q, sum_q}, exp_q);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] r;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'hFFFF, 16'h0000, 1'b1, 17'h10000},
        '{16'h7FFF, 16'h0001, 1'b0, 17'h08000},
        '{16'h8000, 16'h8000, 1'b0, 17'h10000},
        '{16'h8000, 16'h8000, 1'b1, 17'h10001},
        '{16'h1234, 16'h1111, 1'b0, 17'h02345},
        '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF},
        '{16'h0000, 16'h0000, 1'b0, 17'h00000},
        '{16'hA5A5, 16'h5A5A, 1'b0, 17'h0FFFF},
        '{16'h0F0F, 16'h00F1, 1'b0, 17'h01000}
    };

    initial begin
        rst_n = 1'b0;
        a = 16'h1234;
        b = 16'h1111;
        c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_reg", {c_out_q, sum_q}, 17'h0);
        check("reset_comb", {c_out, sum}, 17'h02345);
        chk_q = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_reg", {c_out_q, sum_q}, 17'h02345);
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].a;
            b = vecs[i].b;
            c_in = vecs[i].ci;
            #1;
            check($sformatf("vec%0d_comb", i), {c_out, sum}, vecs[i].r);
            check($sformatf("vec%0d_model", i), {c_out, sum}, model(a, b, c_in));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_reg", i), {c_out_q, sum_q}, vecs[i].r);
        end
        #1;
        a = 16'h0001;
        b = 16'h0002;
        c_in = 1'b0;
        #1;
        check("midcycle_comb", {c_out, sum}, 17'h00003);
        check("midcycle_reg_hold", {c_out_q, sum_q}, 17'h01000);
        @(posedge clk);
        #1;
        check("midcycle_reg_next", {c_out_q, sum_q}, 17'h00003);
        @(negedge clk);
        rst_n = 1'b0;
        a = 16'h4000;
        b = 16'h4000;
        @(posedge clk);
        #1;
        check("midrst_reg", {c_out_q, sum_q}, 17'h0);
        check("midrst_comb", {c_out, sum}, 17'h08000);
        @(negedge clk);
        rst_n = 1'b1;
        run_clk = 1'b0;
        chk_q = 1'b0;
        for (int i = -32768; i < 32768; i += 128) begin
            for (int j = 0; j < 65536; j += 274) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a = i[15:0];
                    b = j[15:0];
                    c_in = ci[0];
                    #1;
                    check("sweep", {c_out, sum}, model(a, b, c_in));
                end
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
